// File: rtl/add_pkg.sv
// Shared constants and types for the adder result stage.
// Flag bit positions are used both for the output bus and for the sticky register.
package add_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int NFLAGS    = 5;

  localparam int FLG_C = 0;
  localparam int FLG_S = 1;
  localparam int FLG_P = 2;
  localparam int FLG_Z = 3;
  localparam int FLG_V = 4;

  // The encoding doubles as the FIFO occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry synchronous FIFO with valid/ready on both sides.
// in_ready depends only on registered occupancy, never on out_ready.
module result_fifo2
  import add_pkg::*;
#(
  parameter int DW = WIDTH_DEF + NFLAGS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
);

  fifo_state_e   state_q, state_d;
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [DW-1:0] mem_q [2];
  logic          push;
  logic          pop;

  assign in_ready_o  = (state_q != ST_FULL);
  assign out_valid_o = (state_q != ST_EMPTY);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;
  assign out_data_o  = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (push) state_d = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_d = ST_FULL;
        else if (pop && !push) state_d = ST_EMPTY;
      end
      ST_FULL:  if (pop) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: rtl/add_result_stage.sv
// Captures adder sum and flags into a 2-deep buffer, and tracks sticky flags
// plus a saturating overflow-event counter for debug observation.
module add_result_stage
  import add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  Z,
  input  logic              carry,
  input  logic              sign,
  input  logic              parity,
  input  logic              zero,
  input  logic              overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [NFLAGS-1:0] out_flags,
  input  logic              clr_sticky,
  output logic [NFLAGS-1:0] sticky_flags,
  output logic [CNT_W-1:0]  ovf_count
);

  localparam int DW = WIDTH + NFLAGS;

  logic [NFLAGS-1:0] new_flags;
  logic [DW-1:0]     head;
  logic              push;
  logic [NFLAGS-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0]  ovf_q, ovf_d, ovf_base;

  always_comb begin
    new_flags        = '0;
    new_flags[FLG_C] = carry;
    new_flags[FLG_S] = sign;
    new_flags[FLG_P] = parity;
    new_flags[FLG_Z] = zero;
    new_flags[FLG_V] = overflow;
  end

  result_fifo2 #(
    .DW (DW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   ({Z, new_flags}),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (head)
  );

  assign out_data  = head[DW-1:NFLAGS];
  assign out_flags = head[NFLAGS-1:0];
  assign push      = in_valid & in_ready;

  // Clear applies before the new result is merged, so clear+push keeps only the new result.
  always_comb begin
    sticky_d = (clr_sticky ? '0 : sticky_q) | (push ? new_flags : '0);
    ovf_base = clr_sticky ? '0 : ovf_q;
    ovf_d    = ovf_base;
    if (push && overflow && (ovf_base != {CNT_W{1'b1}})) begin
      ovf_d = ovf_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
      ovf_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sticky_flags = sticky_q;
  assign ovf_count    = ovf_q;

endmodule

// File: tb/tb_add_result_stage.sv
// Directed bench for add_result_stage: handshake ordering, sticky/counter
// behaviour, saturation and asynchronous reset.
module tb_add_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Z;
  logic        carry, sign, parity, zero, overflow;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  out_flags;
  logic        clr_sticky;
  logic [4:0]  sticky_flags;
  logic [7:0]  ovf_count;

  int n_chk  = 0;
  int n_pass = 0;

  add_result_stage #(.WIDTH(16), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .Z            (Z),
    .carry        (carry),
    .sign         (sign),
    .parity       (parity),
    .zero         (zero),
    .overflow     (overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_flags    (out_flags),
    .clr_sticky   (clr_sticky),
    .sticky_flags (sticky_flags),
    .ovf_count    (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %s obs=%0h", tag, obs);
    end else begin
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs settle 1 time unit later, inputs change here too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flags argument ordering: {V, Z, P, S, C}
  task automatic drive(input logic v, input logic [15:0] z, input logic [4:0] f);
    in_valid = v;
    Z        = z;
    {overflow, zero, parity, sign, carry} = f;
  endtask

  initial begin
    rst_n      = 1'b0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    drive(1'b0, 16'h0, 5'b0);
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_sticky", 32'(sticky_flags), 32'd0);
    check("rst_ovf", 32'(ovf_count), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 1: single result 1+2
    out_ready = 1'b1;
    drive(1'b1, 16'h0003, 5'b00000);
    tick();
    drive(1'b0, 16'h0, 5'b0);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_data", 32'(out_data), 32'h0003);
    check("t1_sticky", 32'(sticky_flags), 32'd0);
    check("t1_ovf", 32'(ovf_count), 32'd0);
    tick();
    check("t1_drained", 32'(out_valid), 32'd0);

    // 2: fill with consumer stalled, third offer must be refused
    out_ready = 1'b0;
    drive(1'b1, 16'h0000, 5'b01101);
    tick();
    drive(1'b1, 16'h8000, 5'b10010);
    tick();
    check("t2_full_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 16'h1234, 5'b00000);
    tick();
    check("t2_hold_data", 32'(out_data), 32'h0000);
    check("t2_hold_flags", 32'(out_flags), 32'b01101);
    check("t2_still_full", 32'(in_ready), 32'd0);
    drive(1'b0, 16'h0, 5'b0);
    out_ready = 1'b1;
    tick();
    check("t2_pop2_data", 32'(out_data), 32'h8000);
    check("t2_pop2_flags", 32'(out_flags), 32'b10010);
    check("t2_ready_back", 32'(in_ready), 32'd1);
    tick();
    check("t2_empty", 32'(out_valid), 32'd0);
    check("t2_sticky", 32'(sticky_flags), 32'b11111);
    check("t2_ovf", 32'(ovf_count), 32'd1);

    // 3: full-rate streaming
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'(16'h0100 + i), 5'b00000);
      tick();
      check($sformatf("t3_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("t3_data_%0d", i), 32'(out_data), 32'(16'h0100 + i));
      check($sformatf("t3_ready_%0d", i), 32'(in_ready), 32'd1);
    end
    drive(1'b0, 16'h0, 5'b0);
    tick();
    check("t3_empty", 32'(out_valid), 32'd0);

    // 4: clear coincident with push of 0x8000+0xFFFF
    clr_sticky = 1'b1;
    drive(1'b1, 16'h7FFF, 5'b10001);
    tick();
    clr_sticky = 1'b0;
    drive(1'b0, 16'h0, 5'b0);
    check("t4_sticky", 32'(sticky_flags), 32'b10001);
    check("t4_ovf", 32'(ovf_count), 32'd1);
    check("t4_data", 32'(out_data), 32'h7FFF);
    tick();

    // 5: overflow counter saturation (1 + 300 clamps at 255)
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 16'(i), 5'b10000);
      tick();
      if (i == 200) check("t5_mid", 32'(ovf_count), 32'd202);
    end
    check("t5_sat", 32'(ovf_count), 32'd255);
    for (int i = 0; i < 5; i++) tick();
    drive(1'b0, 16'h0, 5'b0);
    tick();
    check("t5_sat_hold", 32'(ovf_count), 32'd255);

    // 6: asynchronous reset while full
    out_ready = 1'b0;
    drive(1'b1, 16'hAAAA, 5'b00110);
    tick();
    drive(1'b1, 16'h5555, 5'b00100);
    tick();
    drive(1'b0, 16'h0, 5'b0);
    check("t6_full", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_data", 32'(out_data), 32'd0);
    check("t6_rst_sticky", 32'(sticky_flags), 32'd0);
    check("t6_rst_ovf", 32'(ovf_count), 32'd0);
    #10;
    rst_n = 1'b1;
    tick();
    check("t6_ready_after", 32'(in_ready), 32'd1);
    check("t6_valid_after", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
